// File: rtl/dct_block_buffer.sv
// Ping-pong N x N block buffer: raster-order writes in, raster or zig-zag reads out.
// Each bank holds one block; the reader streams a full bank while the writer fills the other.
module dct_block_buffer #(
  parameter int DATA_W      = 16,
  parameter int N           = 8,
  parameter int LEVEL_SHIFT = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] datain,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic              order_sel,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              dout_first,
  output logic              dout_last,
  output logic [15:0]       blk_count
);

  localparam int NN = N * N;
  localparam int CW = $clog2(N);
  localparam int AW = $clog2(NN);
  localparam logic [CW-1:0] EDGE  = CW'(N - 1);
  localparam logic [AW-1:0] WLAST = AW'(NN - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t             r_state, w_state_nxt;
  logic [DATA_W-1:0]  r_mem [2][NN];
  logic [1:0]         r_full;
  logic               r_wptr, r_rptr;
  logic [AW-1:0]      r_widx;
  logic [CW-1:0]      r_r, r_c;
  logic               r_zz;
  logic [DATA_W-1:0]  r_dout;
  logic               r_dvalid, r_first, r_last;
  logic [15:0]        r_blk;

  logic               w_wr, w_start, w_xfer, w_final;
  logic [CW-1:0]      w_nr, w_nc;
  logic [AW-1:0]      w_raddr;
  logic [DATA_W-1:0]  w_shifted;

  assign din_ready  = reset & ~r_full[r_wptr];
  assign w_wr       = din_valid & din_ready;
  assign w_shifted  = datain - DATA_W'(LEVEL_SHIFT);

  assign w_start    = (r_state == IDLE) && r_full[r_rptr];
  assign w_xfer     = (r_state == STREAM) && r_dvalid && dout_ready;
  assign w_final    = w_xfer && (r_r == EDGE) && (r_c == EDGE);
  assign w_raddr    = AW'(w_nr) * AW'(N) + AW'(w_nc);

  assign dout       = r_dout;
  assign dout_valid = r_dvalid;
  assign dout_first = r_first;
  assign dout_last  = r_last;
  assign blk_count  = r_blk;

  // Storage has no reset so it can map onto RAM; stale contents are never read.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr][r_widx] <= w_shifted;
  end

  // Next (row, col) of the readout walk; parity of r+c picks the zig-zag diagonal direction.
  always_comb begin
    w_nr = r_r;
    w_nc = r_c;
    if (!r_zz) begin
      if (r_c == EDGE) begin
        w_nc = '0;
        w_nr = r_r + CW'(1);
      end else begin
        w_nc = r_c + CW'(1);
      end
    end else if (!(r_r[0] ^ r_c[0])) begin
      if (r_c == EDGE) begin
        w_nr = r_r + CW'(1);
      end else if (r_r == '0) begin
        w_nc = r_c + CW'(1);
      end else begin
        w_nr = r_r - CW'(1);
        w_nc = r_c + CW'(1);
      end
    end else begin
      if (r_r == EDGE) begin
        w_nc = r_c + CW'(1);
      end else if (r_c == '0) begin
        w_nr = r_r + CW'(1);
      end else begin
        w_nr = r_r + CW'(1);
        w_nc = r_c - CW'(1);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_start) w_state_nxt = STREAM;
      STREAM:  if (w_final) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_full   <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_widx   <= '0;
      r_r      <= '0;
      r_c      <= '0;
      r_zz     <= 1'b0;
      r_dout   <= '0;
      r_dvalid <= 1'b0;
      r_first  <= 1'b0;
      r_last   <= 1'b0;
      r_blk    <= '0;
    end else begin
      if (w_wr) begin
        if (r_widx == WLAST) begin
          r_widx         <= '0;
          r_full[r_wptr] <= 1'b1;
          r_wptr         <= ~r_wptr;
        end else begin
          r_widx <= r_widx + AW'(1);
        end
      end
      // Writer only ever sets the write bank and reader only clears the read bank,
      // and those differ whenever both act in the same cycle.
      if (w_start) begin
        r_zz     <= order_sel;
        r_r      <= '0;
        r_c      <= '0;
        r_dout   <= r_mem[r_rptr][0];
        r_dvalid <= 1'b1;
        r_first  <= 1'b1;
        r_last   <= 1'b0;
      end else if (w_final) begin
        r_full[r_rptr] <= 1'b0;
        r_rptr         <= ~r_rptr;
        r_blk          <= r_blk + 16'd1;
        r_dvalid       <= 1'b0;
        r_first        <= 1'b0;
        r_last         <= 1'b0;
      end else if (w_xfer) begin
        r_r     <= w_nr;
        r_c     <= w_nc;
        r_dout  <= r_mem[r_rptr][w_raddr];
        r_first <= 1'b0;
        r_last  <= (w_nr == EDGE) && (w_nc == EDGE);
      end
    end
  end

endmodule

// File: tb/tb_dct_block_buffer.sv
// Directed bench for dct_block_buffer: raster/zig-zag readout, backpressure, level shift, mid-block reset.
module tb_dct_block_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nchk = 0, nerr = 0;

  // main instance: N=8, no level shift
  logic [15:0] din, dout, bcnt;
  logic dvld, drdy, osel, ovld, ordy, ofirst, olast;

  dct_block_buffer #(.DATA_W(16), .N(8), .LEVEL_SHIFT(0)) u_dut (
    .clk(clk), .reset(rst), .datain(din), .din_valid(dvld), .din_ready(drdy),
    .order_sel(osel), .dout(dout), .dout_valid(ovld), .dout_ready(ordy),
    .dout_first(ofirst), .dout_last(olast), .blk_count(bcnt));

  // N=4 instance for the small zig-zag table
  logic [15:0] din4, dout4, bcnt4;
  logic dvld4, drdy4, osel4, ovld4, first4, last4;
  logic ordy4 = 1'b1;

  dct_block_buffer #(.DATA_W(16), .N(4), .LEVEL_SHIFT(0)) u_n4 (
    .clk(clk), .reset(rst), .datain(din4), .din_valid(dvld4), .din_ready(drdy4),
    .order_sel(osel4), .dout(dout4), .dout_valid(ovld4), .dout_ready(ordy4),
    .dout_first(first4), .dout_last(last4), .blk_count(bcnt4));

  // N=2 instance with level shift 128
  logic [15:0] dins, douts, bcnts;
  logic dvlds, drdys, ovlds, firsts, lasts;
  logic ordys = 1'b1;
  logic osels = 1'b0;

  dct_block_buffer #(.DATA_W(16), .N(2), .LEVEL_SHIFT(128)) u_ls (
    .clk(clk), .reset(rst), .datain(dins), .din_valid(dvlds), .din_ready(drdys),
    .order_sel(osels), .dout(douts), .dout_valid(ovlds), .dout_ready(ordys),
    .dout_first(firsts), .dout_last(lasts), .blk_count(bcnts));

  int zz8 [64] = '{ 0, 1, 8,16, 9, 2, 3,10,17,24,32,25,18,11, 4, 5,
                   12,19,26,33,40,48,41,34,27,20,13, 6, 7,14,21,28,
                   35,42,49,56,57,50,43,36,29,22,15,23,30,37,44,51,
                   58,59,52,45,38,31,39,46,53,60,61,54,47,55,62,63};
  int zz4 [16] = '{0,1,4,8,5,2,3,6,9,12,13,10,7,11,14,15};
  int lsin [4] = '{16'h1C00, 16'h0000, 16'h0080, 16'h0081};
  int lsexp[4] = '{16'h1B80, 16'hFF80, 16'h0000, 16'h0001};

  // transfers are sampled on the falling edge, one half-cycle before the edge that takes them
  int oq[$], fq[$], lq[$], cq[$], drl[$], dra[$];
  logic pend = 1'b0;
  always @(negedge clk) begin
    if (pend) dra.push_back(int'(drdy));
    if (ovld && ordy) begin
      oq.push_back(int'(dout)); fq.push_back(int'(ofirst));
      lq.push_back(int'(olast)); cq.push_back(cyc);
      if (olast) drl.push_back(int'(drdy));
    end
    pend <= ovld && ordy && olast;
  end

  int q4[$], l4[$], qs[$];
  always @(negedge clk) begin
    if (ovld4 && ordy4) begin q4.push_back(int'(dout4)); l4.push_back(int'(last4)); end
    if (ovlds && ordys) qs.push_back(int'(douts));
  end

  task automatic chk(input string tag, input int got, input int exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clrq();
    oq.delete(); fq.delete(); lq.delete(); cq.delete(); drl.delete(); dra.delete();
  endtask

  // call at posedge+1; returns at posedge+1 after the last accept
  task automatic feed(input int base, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      int k;
      din  = 16'(base + i);
      dvld = 1'b1;
      k = 0;
      do begin @(negedge clk); k++; end while (!drdy && k < 300);
      if (!drdy) chk("feed_stall", 0, 1);
      @(posedge clk); #1;
    end
    dvld = 1'b0;
  endtask

  task automatic wait_out(input string tag, input int n);
    for (int k = 0; k < 2000 && oq.size() < n; k++) @(posedge clk);
    chk(tag, oq.size(), n);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; din = '0; dvld = 1'b0; osel = 1'b0; ordy = 1'b1;
    din4 = '0; dvld4 = 1'b0; osel4 = 1'b0; dins = '0; dvlds = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("rst_drdy", int'(drdy), 0);
    chk("rst_ovld", int'(ovld), 0);
    chk("rst_bcnt", int'(bcnt), 0);
    chk("rst_dout", int'(dout), 0);
    chk("rst_first", int'(ofirst), 0);
    chk("rst_last", int'(olast), 0);
    rst = 1'b1;
    @(negedge clk);
    chk("drdy_up", int'(drdy), 1);
    @(posedge clk); #1;

    // raster block, first valid exactly one edge after the last accept
    clrq();
    feed(0, 64);
    @(negedge clk); chk("vld_early", int'(ovld), 0);
    @(negedge clk); chk("vld_rise", int'(ovld), 1);
    chk("first_hi", int'(ofirst), 1);
    chk("dout0", int'(dout), 0);
    wait_out("t1_cnt", 64);
    for (int i = 0; i < 64; i++) chk($sformatf("ras[%0d]", i), oq[i], i);
    chk("t1_first0", fq[0], 1); chk("t1_first1", fq[1], 0);
    chk("t1_last62", lq[62], 0); chk("t1_last63", lq[63], 1);
    chk("t1_bcnt", int'(bcnt), 1);

    // zig-zag N=8
    clrq();
    osel = 1'b1;
    feed(0, 64);
    wait_out("t2_cnt", 64);
    osel = 1'b0;
    for (int i = 0; i < 64; i++) chk($sformatf("zz8[%0d]", i), oq[i], zz8[i]);
    chk("t2_last62", lq[62], 0); chk("t2_last63", lq[63], 1);
    chk("t2_bcnt", int'(bcnt), 2);

    // both banks fill under backpressure, then drain
    clrq();
    ordy = 1'b0;
    feed(300, 128);
    @(negedge clk); chk("rdy_full", int'(drdy), 0);
    repeat (4) @(negedge clk);
    chk("rdy_hold", int'(drdy), 0);
    chk("vld_hold", int'(ovld), 1);
    chk("dout_hold", int'(dout), 300);
    chk("first_hold", int'(ofirst), 1);
    @(posedge clk); #1;
    ordy = 1'b1;
    wait_out("t3_cnt", 128);
    for (int i = 0; i < 128; i++) chk($sformatf("bp[%0d]", i), oq[i], 300 + i);
    chk("no_bubble", cq[63] - cq[62], 1);
    chk("one_bubble", cq[64] - cq[63], 2);
    chk("rdy_at_final", drl[0], 0);
    chk("rdy_after_final", dra[0], 1);
    chk("t3_bcnt", int'(bcnt), 4);

    // N=4 zig-zag; order_sel flipped mid-stream, then a raster block
    chk("n4_rdy", int'(drdy4), 1);
    osel4 = 1'b1;
    for (int i = 0; i < 16; i++) begin din4 = 16'(i); dvld4 = 1'b1; @(posedge clk); #1; end
    dvld4 = 1'b0;
    for (int k = 0; k < 200 && q4.size() < 3; k++) @(posedge clk);
    #1 osel4 = 1'b0;
    for (int k = 0; k < 200 && q4.size() < 16; k++) @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) begin din4 = 16'(16 + i); dvld4 = 1'b1; @(posedge clk); #1; end
    dvld4 = 1'b0;
    for (int k = 0; k < 200 && q4.size() < 32; k++) @(posedge clk);
    #1;
    chk("n4_cnt", q4.size(), 32);
    if (q4.size() == 32) begin
      for (int i = 0; i < 16; i++) chk($sformatf("zz4[%0d]", i), q4[i], zz4[i]);
      for (int i = 0; i < 16; i++) chk($sformatf("n4ras[%0d]", i), q4[16 + i], 16 + i);
      chk("n4_last14", l4[14], 0); chk("n4_last15", l4[15], 1);
    end
    chk("n4_bcnt", int'(bcnt4), 2);

    // level shift on the N=2 instance
    for (int i = 0; i < 4; i++) begin dins = 16'(lsin[i]); dvlds = 1'b1; @(posedge clk); #1; end
    dvlds = 1'b0;
    for (int k = 0; k < 200 && qs.size() < 4; k++) @(posedge clk);
    #1;
    chk("ls_cnt", qs.size(), 4);
    if (qs.size() == 4)
      for (int i = 0; i < 4; i++) chk($sformatf("ls[%0d]", i), qs[i], lsexp[i]);

    // reset after a partial block discards it
    clrq();
    feed(1000, 30);
    chk("bcnt_pre", int'(bcnt), 4);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_vld", int'(ovld), 0);
    chk("mid_rst_bcnt", int'(bcnt), 0);
    chk("mid_rst_rdy", int'(drdy), 0);
    rst = 1'b1;
    feed(2000, 64);
    wait_out("t4_cnt", 64);
    for (int i = 0; i < 64; i++) chk($sformatf("new[%0d]", i), oq[i], 2000 + i);
    chk("t4_bcnt", int'(bcnt), 1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/dct_block_buffer.md
DCT_BLOCK_BUFFER -- requirements
Module: dct_block_buffer

Interface
REQ-001 Parameters SHALL be:
- DATA_W, 16, sample width in bits.
- N, 8, block edge; legal values 2..16; block holds N*N samples.
- LEVEL_SHIFT, 0, constant subtracted from every sample on write.
REQ-002 Ports SHALL be:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  synchronous active-low reset.
- datain  in  DATA_W  input sample, raster order (row-major).
- din_valid  in  1  datain valid.
- din_ready  out  1  buffer can accept datain.
- order_sel  in  1  readout order: 0 raster, 1 zig-zag; sampled at block start.
- dout  out  DATA_W  output sample.
- dout_valid  out  1  dout valid.
- dout_ready  in  1  downstream accepts dout.
- dout_first  out  1  dout is element 0 of a block.
- dout_last  out  1  dout is element N*N-1 of a block.
- blk_count  out  16  blocks fully emitted, modulo 2^16.
REQ-003 Clock and reset SHALL be one clock (clk) and a synchronous, active-low reset (reset); no other clock or reset.

Function
REQ-004 Two banks of N*N entries (ping-pong) with per-bank full flag, write-bank pointer, read-bank pointer.
REQ-005 Input transfer occurs on an edge with din_valid=1 and din_ready=1; otherwise datain is ignored.
REQ-006 din_ready = reset high AND full flag of the write bank clear; combinational.
REQ-007 Accepted sample stored as (datain - LEVEL_SHIFT) mod 2^DATA_W at the next raster address of the write bank.
REQ-008 On the edge accepting sample N*N-1: set write-bank full flag, toggle write pointer, clear write index.
REQ-009 Read FSM states IDLE, STREAM; reset state IDLE.
REQ-010 IDLE -> STREAM on the edge where read-bank full flag is set; same edge latches order_sel, loads dout with element (0,0), sets dout_valid=1, dout_first=1.
REQ-011 dout_valid rises on the first edge after the edge accepting the last input sample of a block, when read side is IDLE.
REQ-012 STREAM: output transfer on an edge with dout_valid=1 and dout_ready=1; dout, dout_first, dout_last hold stable while dout_ready=0.
REQ-013 On a non-final transfer: advance (r,c), load next element on the same edge; no bubble within a block.
REQ-014 Raster walk: c+1; at c=N-1 wrap c=0, r+1.
REQ-015 Zig-zag walk, (r+c) even: c=N-1 -> r+1; else r=0 -> c+1; else r-1,c+1. (r+c) odd: r=N-1 -> c+1; else c=0 -> r+1; else r+1,c-1.
REQ-016 dout_last=1 exactly when (r,c)=(N-1,N-1).
REQ-017 On final transfer: clear read-bank full flag, toggle read pointer, blk_count+1 (65535 wraps to 0), dout_valid=0, go IDLE; next block, if full, appears one cycle later (one bubble cycle between blocks).
REQ-018 Freed bank is writable from the cycle after the final transfer; write and read of different banks proceed concurrently.
REQ-019 order_sel changes during STREAM have no effect until the next block start.

Reset
REQ-020 reset low at an edge: FSM IDLE, both full flags 0, pointers and indices 0, dout=0, dout_valid=0, dout_first=0, dout_last=0, blk_count=0; din_ready=0 while reset low.
REQ-021 Reset mid-block discards all partially written and unread data; bank contents need not be cleared.

Verification
REQ-022 N=8, order_sel=0, dout_ready=1, feed 0..63 -> dout 0..63, dout_first on 0, dout_last on 63, blk_count=1.
REQ-023 N=8, order_sel=1, feed 0..63 -> dout 0,1,8,16,9,2,3,10,17,24,...,62,63; dout_last on 63.
REQ-024 N=4, order_sel=1, feed 0..15 -> 0,1,4,8,5,2,3,6,9,12,13,10,7,11,14,15; order_sel toggled mid-stream has no effect.
REQ-025 dout_ready=0, din_valid=1 continuously -> din_ready falls after 128 accepted and stays low; dout_ready=1 -> 128 outputs in order, no loss, one bubble between blocks, din_ready rises the cycle after each block's final transfer.
REQ-026 LEVEL_SHIFT=128, DATA_W=16: datain 16'h1C00 -> dout 16'h1B80; datain 16'h0000 -> dout 16'hFF80.
REQ-027 Reset low one cycle after 30 inputs -> dout_valid=0, blk_count=0; then 64 new samples -> one block of only new data, blk_count=1.
